set_assoc_blockram: RTL and testbench

SET_ASSOC_BLOCKRAM -- requirements
Module: set_assoc_blockram

---
 rtl/set_assoc_blockram.sv | 123 ++++++++++++
 tb/tb_set_assoc_blockram.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/set_assoc_blockram.sv
// Set-associative block RAM: NUM_SET rows of NUM_WAY entries, self-clearing after reset,
// with a registered read port and a masked write port that reports the evicted set contents.
// Optional macro SET_ASSOC_BLOCKRAM_WRITE_FORWARD_EN forwards same-set write data to the read result.
module set_assoc_blockram #(
    parameter int SINGLE_ENTRY_SIZE_IN_BITS = 64,
    parameter int NUM_SET                   = 64,
    parameter int SET_PTR_WIDTH_IN_BITS     = 6,
    parameter int NUM_WAY                   = 4
) (
    input  logic                                           clk_in,
    input  logic                                           reset_in,
    output logic                                           init_done_out,
    input  logic                                           read_en_in,
    input  logic [SET_PTR_WIDTH_IN_BITS-1:0]               read_set_addr_in,
    output logic                                           read_valid_out,
    output logic [NUM_WAY*SINGLE_ENTRY_SIZE_IN_BITS-1:0]   read_entry_out,
    input  logic                                           write_en_in,
    input  logic [NUM_WAY-1:0]                             write_way_mask_in,
    input  logic [SET_PTR_WIDTH_IN_BITS-1:0]               write_set_addr_in,
    input  logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0]           write_entry_in,
    output logic                                           evict_valid_out,
    output logic [NUM_WAY*SINGLE_ENTRY_SIZE_IN_BITS-1:0]   evict_entry_out
);

    localparam int W     = SINGLE_ENTRY_SIZE_IN_BITS;
    localparam int ROW_W = NUM_WAY * W;
    localparam logic [SET_PTR_WIDTH_IN_BITS-1:0] LAST_SET = SET_PTR_WIDTH_IN_BITS'(NUM_SET - 1);
    localparam logic [SET_PTR_WIDTH_IN_BITS-1:0] ONE      = SET_PTR_WIDTH_IN_BITS'(1);

    typedef enum logic {INIT, READY} state_t;

    state_t                           state_q, state_d;
    logic [SET_PTR_WIDTH_IN_BITS-1:0] cnt_q, cnt_d;
    logic                             rd_vld_q, rd_vld_d;
    logic [ROW_W-1:0]                 rd_entry_q, rd_entry_d;
    logic                             ev_vld_q, ev_vld_d;
    logic [ROW_W-1:0]                 ev_entry_q, ev_entry_d;
    logic [ROW_W-1:0]                 mem_q [NUM_SET];

    logic             rd_acc;
    logic             wr_acc;
    logic [ROW_W-1:0] rd_row;

    assign rd_acc = (state_q == READY) && read_en_in;
    assign wr_acc = (state_q == READY) && write_en_in && (|write_way_mask_in);

    always_comb begin
        rd_row = mem_q[read_set_addr_in];
`ifdef SET_ASSOC_BLOCKRAM_WRITE_FORWARD_EN
        if (wr_acc && (write_set_addr_in == read_set_addr_in)) begin
            for (int w = 0; w < NUM_WAY; w++) begin
                if (write_way_mask_in[w]) begin
                    rd_row[w*W +: W] = write_entry_in;
                end
            end
        end
`endif
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rd_vld_d   = rd_acc;
        rd_entry_d = rd_entry_q;
        ev_vld_d   = wr_acc;
        ev_entry_d = ev_entry_q;
        case (state_q)
            INIT: begin
                cnt_d = cnt_q + ONE;
                if (cnt_q == LAST_SET) begin
                    state_d = READY;
                end
            end
            READY: begin
                if (rd_acc) begin
                    rd_entry_d = rd_row;
                end
                if (wr_acc) begin
                    ev_entry_d = mem_q[write_set_addr_in];
                end
            end
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state_q    <= INIT;
            cnt_q      <= '0;
            rd_vld_q   <= 1'b0;
            rd_entry_q <= '0;
            ev_vld_q   <= 1'b0;
            ev_entry_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rd_vld_q   <= rd_vld_d;
            rd_entry_q <= rd_entry_d;
            ev_vld_q   <= ev_vld_d;
            ev_entry_q <= ev_entry_d;
        end
    end

    // Storage is never reset; the INIT sweep is the only thing that zeroes it.
    always_ff @(posedge clk_in) begin
        if (state_q == INIT) begin
            mem_q[cnt_q] <= '0;
        end else if (wr_acc) begin
            for (int w = 0; w < NUM_WAY; w++) begin
                if (write_way_mask_in[w]) begin
                    mem_q[write_set_addr_in][w*W +: W] <= write_entry_in;
                end
            end
        end
    end

    assign init_done_out   = (state_q == READY);
    assign read_valid_out  = rd_vld_q;
    assign read_entry_out  = rd_entry_q;
    assign evict_valid_out = ev_vld_q;
    assign evict_entry_out = ev_entry_q;

endmodule

// File: tb/tb_set_assoc_blockram.sv
// Randomized + directed bench for set_assoc_blockram (W=8, 4 sets, 2 ways) against a
// behavioural array model; honours SET_ASSOC_BLOCKRAM_WRITE_FORWARD_EN when defined.
module tb_set_assoc_blockram;

    localparam int W    = 8;
    localparam int NSET = 4;
    localparam int NWAY = 2;
    localparam int AW   = 2;

    logic              clk, rst;
    logic              init_done;
    logic              read_en;
    logic [AW-1:0]     read_addr;
    logic              read_valid;
    logic [NWAY*W-1:0] read_entry;
    logic              write_en;
    logic [NWAY-1:0]   write_mask;
    logic [AW-1:0]     write_addr;
    logic [W-1:0]      write_data;
    logic              evict_valid;
    logic [NWAY*W-1:0] evict_entry;

    set_assoc_blockram #(
        .SINGLE_ENTRY_SIZE_IN_BITS(W),
        .NUM_SET(NSET),
        .SET_PTR_WIDTH_IN_BITS(AW),
        .NUM_WAY(NWAY)
    ) dut (
        .clk_in(clk),
        .reset_in(rst),
        .init_done_out(init_done),
        .read_en_in(read_en),
        .read_set_addr_in(read_addr),
        .read_valid_out(read_valid),
        .read_entry_out(read_entry),
        .write_en_in(write_en),
        .write_way_mask_in(write_mask),
        .write_set_addr_in(write_addr),
        .write_entry_in(write_data),
        .evict_valid_out(evict_valid),
        .evict_entry_out(evict_entry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Behavioural model: plain byte array plus a count of clear cycles since reset release.
    logic [W-1:0]      mm [NSET][NWAY];
    int                init_cnt;
    logic              e_rv, e_ev;
    logic [NWAY*W-1:0] e_rd, e_evd;

    function automatic logic [NWAY*W-1:0] row(input int s);
        logic [NWAY*W-1:0] r;
        for (int w = 0; w < NWAY; w++) r[w*W +: W] = mm[s][w];
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_init_done", 32'(init_done), 0);
        chk("rst_read_valid", 32'(read_valid), 0);
        chk("rst_read_entry", 32'(read_entry), 0);
        chk("rst_evict_valid", 32'(evict_valid), 0);
        chk("rst_evict_entry", 32'(evict_entry), 0);
        init_cnt = 0;
        e_rv = 0; e_ev = 0; e_rd = '0; e_evd = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Apply one cycle of inputs, advance the model, then compare every output after the edge.
    task automatic cycle(input logic ren, input logic [AW-1:0] ra, input logic wen,
                         input logic [NWAY-1:0] wm, input logic [AW-1:0] wa, input logic [W-1:0] wd);
        read_en = ren; read_addr = ra;
        write_en = wen; write_mask = wm; write_addr = wa; write_data = wd;
        if (init_cnt < NSET) begin
            for (int w = 0; w < NWAY; w++) mm[init_cnt][w] = '0;
            init_cnt++;
            e_rv = 0; e_ev = 0;
        end else begin
            e_rv = ren;
            if (ren) begin
                e_rd = row(ra);
`ifdef SET_ASSOC_BLOCKRAM_WRITE_FORWARD_EN
                if (wen && wm != 0 && wa == ra)
                    for (int w = 0; w < NWAY; w++) if (wm[w]) e_rd[w*W +: W] = wd;
`endif
            end
            e_ev = wen && (wm != 0);
            if (e_ev) begin
                e_evd = row(wa);
                for (int w = 0; w < NWAY; w++) if (wm[w]) mm[wa][w] = wd;
            end
        end
        @(posedge clk);
        #1;
        chk("init_done", 32'(init_done), 32'(init_cnt >= NSET));
        chk("read_valid", 32'(read_valid), 32'(e_rv));
        chk("read_entry", 32'(read_entry), 32'(e_rd));
        chk("evict_valid", 32'(evict_valid), 32'(e_ev));
        chk("evict_entry", 32'(evict_entry), 32'(e_evd));
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 0; read_en = 0; read_addr = 0; write_en = 0;
        write_mask = 0; write_addr = 0; write_data = 0;
        init_cnt = 0;
        #1;
        do_reset();

        // Clear sequence with read held high: four INIT cycles, no read results.
        for (int i = 0; i < NSET; i++) begin
            cycle(1, 2, 0, 0, 0, 0);
            chk("lit_init_rv", 32'(read_valid), 0);
        end
        chk("lit_init_done", 32'(init_done), 1);
        cycle(1, 2, 0, 0, 0, 0);
        chk("lit_first_read", 32'(read_entry), 32'h0000);
        chk("lit_first_rv", 32'(read_valid), 1);

        // Masked writes to set 1 and eviction of the prior contents.
        cycle(0, 0, 1, 2'b01, 1, 8'hA5);
        chk("lit_ev1", 32'(evict_entry), 32'h0000);
        cycle(0, 0, 1, 2'b10, 1, 8'h3C);
        chk("lit_ev2", 32'(evict_entry), 32'h00A5);
        cycle(1, 1, 0, 0, 0, 0);
        chk("lit_rd_set1", 32'(read_entry), 32'h3CA5);

        // Same-cycle read/write on set 3.
        cycle(1, 3, 1, 2'b11, 3, 8'h77);
`ifdef SET_ASSOC_BLOCKRAM_WRITE_FORWARD_EN
        chk("lit_same_set_rd", 32'(read_entry), 32'h7777);
`else
        chk("lit_same_set_rd", 32'(read_entry), 32'h0000);
`endif
        chk("lit_same_set_ev", 32'(evict_entry), 32'h0000);

        // Zero mask is a no-op.
        cycle(0, 0, 1, 2'b00, 0, 8'hFF);
        chk("lit_zero_mask_ev", 32'(evict_valid), 0);
        cycle(1, 0, 0, 0, 0, 0);
        chk("lit_zero_mask_rd", 32'(read_entry), 32'h0000);

        // Independent read of set 0 and write of set 2.
        cycle(1, 0, 1, 2'b10, 2, 8'h5A);
        chk("lit_indep_rd", 32'(read_entry), 32'h0000);
        chk("lit_indep_ev", 32'(evict_entry), 32'h0000);
        cycle(1, 2, 0, 0, 0, 0);
        chk("lit_rd_set2", 32'(read_entry), 32'h5A00);

        // Reset during READY restarts the clear sequence.
        cycle(0, 0, 1, 2'b01, 0, 8'h11);
        do_reset();
        for (int i = 0; i < NSET; i++) cycle(1, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0);
        chk("lit_after_reset_rd", 32'(read_entry), 32'h0000);
        chk("lit_after_reset_rv", 32'(read_valid), 1);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else if ($urandom_range(0, 9) == 0) begin
                idle();
            end else begin
                cycle(1'($urandom_range(0, 1)), AW'($urandom_range(0, NSET-1)),
                      1'($urandom_range(0, 1)), NWAY'($urandom_range(0, (1<<NWAY)-1)),
                      AW'($urandom_range(0, NSET-1)), W'($urandom_range(0, 255)));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
